// File: rtl/comparador_pagamento.sv
// Payment comparator for the vending controller: collects coin credit against a latched price,
// releases the product, pays change one unit per pulse and hands control back with a one-cycle OK.
module comparador_pagamento #(
  parameter int W       = 8,
  parameter int MOEDA_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         estados,
  input  logic [W-1:0]       preco,
  input  logic               moeda_valida,
  input  logic [MOEDA_W-1:0] moeda_valor,
  input  logic               cancelar,
  output logic               OK,
  output logic               liberar,
  output logic               troco_pulso,
  output logic [W:0]         credito,
  output logic               vendido
);

  localparam logic [1:0] COMPARADOR = 2'b10;

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] COLETA  = 3'd1;
  localparam logic [2:0] ENTREGA = 3'd2;
  localparam logic [2:0] DEVOLVE = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;

  localparam logic [W:0] UM = {{W{1'b0}}, 1'b1};

  logic [2:0]   estado_q, estado_d;
  logic [W:0]   credito_q, credito_d;
  logic [W:0]   restante_q, restante_d;
  logic [W-1:0] preco_q, preco_d;
  logic         vendido_q, vendido_d;

  logic [W:0]   soma;
  logic [W:0]   precoExt;

  // Credit never wraps: the largest reachable sum is price-1 plus one maximum coin.
  assign precoExt = {1'b0, preco_q};
  assign soma     = credito_q + (moeda_valida ? {{(W+1-MOEDA_W){1'b0}}, moeda_valor} : '0);

  always_comb begin
    estado_d   = estado_q;
    credito_d  = credito_q;
    restante_d = restante_q;
    preco_d    = preco_q;
    vendido_d  = vendido_q;
    case (estado_q)
      OCIOSO: begin
        credito_d = '0;
        if (estados == COMPARADOR) begin
          preco_d   = preco;
          vendido_d = 1'b0;
          estado_d  = COLETA;
        end
      end
      COLETA: begin
        credito_d = soma;
        // Cancel/abort outranks reaching the price, so a coin landing with cancel is refunded.
        if (cancelar || (estados != COMPARADOR)) begin
          restante_d = soma;
          estado_d   = DEVOLVE;
        end else if (soma >= precoExt) begin
          estado_d = ENTREGA;
        end
      end
      ENTREGA: begin
        vendido_d  = 1'b1;
        restante_d = credito_q - precoExt;
        estado_d   = DEVOLVE;
      end
      DEVOLVE: begin
        if (restante_q != '0) begin
          restante_d = restante_q - UM;
        end else begin
          estado_d = FIM;
        end
      end
      FIM: begin
        credito_d = '0;
        estado_d  = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      credito_q  <= '0;
      restante_q <= '0;
      preco_q    <= '0;
      vendido_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      credito_q  <= credito_d;
      restante_q <= restante_d;
      preco_q    <= preco_d;
      vendido_q  <= vendido_d;
    end
  end

  assign OK          = (estado_q == FIM);
  assign liberar     = (estado_q == ENTREGA);
  assign troco_pulso = (estado_q == DEVOLVE) && (restante_q != '0);
  assign credito     = credito_q;
  assign vendido     = vendido_q;

endmodule
